mem_beat_bridge: RTL and testbench
==================================

// Module: mem_beat_bridge
// PURPOSE
//  Memory-side neighbour of the 128-bit RISC core. Takes the core's word access
//  (Address, mw_en, Alu_Out as write data) and serialises it into four 32-bit
//  beats on a valid/ready memory bus. Read beats are reassembled into a 128-bit
//  word that drives the core's D_in. busy tells the control unit to stall.
// PARAMETERS
//  ADDR_W  16   word address width (matches core Address)
//  WORD_W  128  core data width
//  BUS_W   32   memory bus data width; BEATS = WORD_W/BUS_W = 4
// PORTS
//  clk        in   1       system clock
//  reset      in   1       synchronous, active-high reset
//  cpu_req    in   1       access request, sampled only in IDLE
//  cpu_we     in   1       1=write, 0=read (core mw_en)
//  cpu_addr   in   ADDR_W  base word address (core Address)
//  cpu_wdata  in   WORD_W  write data (core Alu_Out)
//  cpu_rdata  out  WORD_W  assembled read data (to core D_in)
//  cpu_done   out  1       one-cycle completion pulse
//  busy       out  1       high from the cycle after request accept until cpu_done
//  bus_valid  out  1       beat request valid
//  bus_ready  in   1       memory accepts beat
//  bus_we     out  1       beat is a write
//  bus_addr   out  ADDR_W  beat address
//  bus_wdata  out  BUS_W   beat write data
//  bus_rvalid in   1       read data valid
//  bus_rdata  in   BUS_W   read data
// BEHAVIOUR
//  Reset: state=IDLE. cpu_rdata, cpu_done, busy, bus_valid, bus_we, bus_addr,
//   bus_wdata and beat counter are all 0.
//  FSM states: IDLE, WR_BEAT, RD_ADDR, RD_DATA, DONE.
//  IDLE: cpu_req=1 latches addr, wdata and we, clears beat cnt k=0, and moves to
//   WR_BEAT (we=1) or RD_ADDR (we=0).
//  Beat k carries bits [32k+31:32k]. bus_addr = addr+k, mod 2^ADDR_W (wraps).
//  WR_BEAT: bus_valid=1, bus_we=1. On valid&ready: k++. After the k=3 accept,
//   go to DONE.
//  RD_ADDR: bus_valid=1, bus_we=0. On ready, go to RD_DATA. In RD_DATA: on
//   bus_rvalid, store bus_rdata into shadow slot k and k++. After slot 3, go to
//   DONE. Otherwise return to RD_ADDR.
//  bus_valid/addr/wdata/we are held stable until ready. Never withdrawn except by reset.
//  DONE: cpu_done=1 for exactly one cycle, then IDLE. On a read, cpu_rdata loads
//   the shadow on entry to DONE. cpu_rdata holds until the next read completes.
//   Writes never change cpu_rdata.
//  Latency (ready=1, rvalid one cycle after accept): write done at 5 cycles
//   after req. Read done at 9 cycles after req.
//  cpu_req outside IDLE is ignored. bus_rvalid outside RD_DATA is ignored.
//  bus_ready outside RD_ADDR/WR_BEAT is ignored.
//  Reset mid-transfer: IDLE next cycle, partial shadow discarded, cpu_rdata=0, no done.
// CONFIGURATION
//  BRIDGE_PARITY_EN defined:
//   - Adds bus_wpar (out, 1) = ^bus_wdata, even parity.
//   - Adds bus_rpar (in, 1), checked on every accepted read beat.
//   - Adds par_err (out, 1). A mismatch sets par_err (sticky). Cleared by reset
//     or by the next accepted cpu_req. Transfer still completes normally.
//  BRIDGE_PARITY_EN undefined: those ports and that logic do not exist.
// TESTING
//  1 Write addr=0x0010, wdata=0x44..33..22..11 (32-bit lanes), ready=1 ->
//    beats to 0x10..0x13 with data 11,22,33,44, cpu_done at cycle 5.
//  2 Read addr=0x0020, rdata per beat A0,B1,C2,D3 -> cpu_rdata={D3,C2,B1,A0},
//    cpu_done at cycle 9.
//  3 Write with bus_ready low for 3 cycles on beat 1 -> bus_addr/bus_wdata
//    stable while stalled, done delayed by 3 cycles.
//  4 Read addr=0xFFFE -> beat addresses FFFE, FFFF, 0000, 0001.
//  5 reset asserted during beat 2 of a read -> IDLE, all outputs 0, no
//    cpu_done. A new read then completes correctly.
//  6 (BRIDGE_PARITY_EN) wrong bus_rpar on beat 1 -> par_err=1 after that beat,
//    held until next cpu_req.

Source files
------------

// File: rtl/mem_beat_bridge.sv
// mem_beat_bridge: serialises a 128-bit core word access into 32-bit beats on a
// valid/ready memory bus and reassembles read beats into a word for the core.
// Optional feature macro: BRIDGE_PARITY_EN adds even parity on write beats
// (bus_wpar), checks read beats against bus_rpar and reports a sticky par_err.
module mem_beat_bridge #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 128,
    parameter int BUS_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              busy,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [BUS_W-1:0]  bus_wdata,
    input  logic              bus_rvalid,
`ifdef BRIDGE_PARITY_EN
    output logic              bus_wpar,
    input  logic              bus_rpar,
    output logic              par_err,
`endif
    input  logic [BUS_W-1:0]  bus_rdata
);

    localparam int BEATS = WORD_W / BUS_W;
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_BEAT = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Even parity of one bus beat (XOR of all data bits).
    function automatic logic even_parity(input logic [BUS_W-1:0] d);
        return ^d;
    endfunction

    state_t                          state_r;
    logic [KW-1:0]                   k_r;
    logic [ADDR_W-1:0]               addr_r;
    logic [BEATS-1:0][BUS_W-1:0]     wdata_r;
    logic [BEATS-1:0][BUS_W-1:0]     shadow_r;
    logic [BEATS-1:0][BUS_W-1:0]     shadow_next_s;
    logic [KW-1:0]                   k_inc_s;
    logic                            k_last_s;
    logic [ADDR_W-1:0]               beat_addr_s;

    // Next-beat bookkeeping: incremented counter, last-beat flag, wrapped address
    // of the following beat, and the shadow word with the current read beat merged.
    always_comb begin
        k_inc_s          = k_r + KW'(1);
        k_last_s         = (k_r == KW'(BEATS - 1));
        beat_addr_s      = addr_r + ADDR_W'(k_inc_s);
        shadow_next_s    = shadow_r;
        shadow_next_s[k_r] = bus_rdata;
    end

    // Transfer FSM with all bus/core outputs registered on the state transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            k_r       <= '0;
            addr_r    <= '0;
            wdata_r   <= '0;
            shadow_r  <= '0;
            cpu_rdata <= '0;
            cpu_done  <= 1'b0;
            busy      <= 1'b0;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
`ifdef BRIDGE_PARITY_EN
            bus_wpar  <= 1'b0;
            par_err   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cpu_done <= 1'b0;
                    if (cpu_req) begin
                        addr_r    <= cpu_addr;
                        wdata_r   <= cpu_wdata;
                        k_r       <= '0;
                        busy      <= 1'b1;
                        bus_valid <= 1'b1;
                        bus_we    <= cpu_we;
                        bus_addr  <= cpu_addr;
`ifdef BRIDGE_PARITY_EN
                        par_err   <= 1'b0;
`endif
                        if (cpu_we) begin
                            bus_wdata <= cpu_wdata[BUS_W-1:0];
`ifdef BRIDGE_PARITY_EN
                            bus_wpar  <= even_parity(cpu_wdata[BUS_W-1:0]);
`endif
                            state_r   <= ST_WR_BEAT;
                        end else begin
                            state_r   <= ST_RD_ADDR;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_WR_BEAT: begin
                    if (bus_ready) begin
                        k_r <= k_inc_s;
                        if (k_last_s) begin
                            bus_valid <= 1'b0;
                            bus_we    <= 1'b0;
                            busy      <= 1'b0;
                            cpu_done  <= 1'b1;
                            state_r   <= ST_DONE;
                        end else begin
                            bus_addr  <= beat_addr_s;
                            bus_wdata <= wdata_r[k_inc_s];
`ifdef BRIDGE_PARITY_EN
                            bus_wpar  <= even_parity(wdata_r[k_inc_s]);
`endif
                            state_r   <= ST_WR_BEAT;
                        end
                    end else begin
                        state_r <= ST_WR_BEAT;
                    end
                end

                ST_RD_ADDR: begin
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        state_r   <= ST_RD_DATA;
                    end else begin
                        state_r <= ST_RD_ADDR;
                    end
                end

                ST_RD_DATA: begin
                    if (bus_rvalid) begin
                        shadow_r <= shadow_next_s;
                        k_r      <= k_inc_s;
`ifdef BRIDGE_PARITY_EN
                        if (even_parity(bus_rdata) != bus_rpar) begin
                            par_err <= 1'b1;
                        end
`endif
                        if (k_last_s) begin
                            cpu_rdata <= shadow_next_s;
                            busy      <= 1'b0;
                            cpu_done  <= 1'b1;
                            state_r   <= ST_DONE;
                        end else begin
                            bus_valid <= 1'b1;
                            bus_addr  <= beat_addr_s;
                            state_r   <= ST_RD_ADDR;
                        end
                    end else begin
                        state_r <= ST_RD_DATA;
                    end
                end

                ST_DONE: begin
                    cpu_done <= 1'b0;
                    state_r  <= ST_IDLE;
                end

                default: begin
                    bus_valid <= 1'b0;
                    bus_we    <= 1'b0;
                    busy      <= 1'b0;
                    cpu_done  <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_beat_bridge.sv
// Directed self-checking bench for mem_beat_bridge: writes, reads, bus stalls,
// address wrap, mid-transfer reset and (with BRIDGE_PARITY_EN) read parity errors.
module tb_mem_beat_bridge;

    logic         clk;
    logic         reset;
    logic         cpu_req;
    logic         cpu_we;
    logic [15:0]  cpu_addr;
    logic [127:0] cpu_wdata;
    logic [127:0] cpu_rdata;
    logic         cpu_done;
    logic         busy;
    logic         bus_valid;
    logic         bus_ready;
    logic         bus_we;
    logic [15:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic         bus_rvalid;
    logic [31:0]  bus_rdata;
`ifdef BRIDGE_PARITY_EN
    logic         bus_wpar;
    logic         bus_rpar;
    logic         par_err;
`endif

    int checks = 0;
    int errors = 0;

    mem_beat_bridge #(.ADDR_W(16), .WORD_W(128), .BUS_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_done   (cpu_done),
        .busy       (busy),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rvalid (bus_rvalid),
`ifdef BRIDGE_PARITY_EN
        .bus_wpar   (bus_wpar),
        .bus_rpar   (bus_rpar),
        .par_err    (par_err),
`endif
        .bus_rdata  (bus_rdata)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One active edge, then settle at the falling edge where outputs are sampled.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full write; optionally hold bus_ready low for stall_n cycles on beat stall_k.
    task automatic do_write(input logic [15:0] a, input logic [127:0] d,
                            input int stall_k, input int stall_n,
                            input logic [127:0] keep_rdata);
        logic [15:0] ea;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d; bus_ready = 1'b1;
        tick();
        cpu_req = 1'b0; cpu_wdata = '0;
        check("wr_busy", {127'd0, busy}, 128'd1);
`ifdef BRIDGE_PARITY_EN
        check("wr_par_clr", {127'd0, par_err}, 128'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            ea = a + 16'(i);
            check("wr_valid", {127'd0, bus_valid}, 128'd1);
            check("wr_we", {127'd0, bus_we}, 128'd1);
            check("wr_addr", {112'd0, bus_addr}, {112'd0, ea});
            check("wr_data", {96'd0, bus_wdata}, {96'd0, d[32*i +: 32]});
`ifdef BRIDGE_PARITY_EN
            check("wr_par", {127'd0, bus_wpar}, {127'd0, ^d[32*i +: 32]});
`endif
            check("wr_nodone", {127'd0, cpu_done}, 128'd0);
            if (i == stall_k) begin
                bus_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    check("stall_valid", {127'd0, bus_valid}, 128'd1);
                    check("stall_addr", {112'd0, bus_addr}, {112'd0, ea});
                    check("stall_data", {96'd0, bus_wdata}, {96'd0, d[32*i +: 32]});
                end
                bus_ready = 1'b1;
            end
            tick();
        end
        check("wr_done", {127'd0, cpu_done}, 128'd1);
        check("wr_busy_off", {127'd0, busy}, 128'd0);
        check("wr_valid_off", {127'd0, bus_valid}, 128'd0);
        check("wr_keep_rdata", cpu_rdata, keep_rdata);
        tick();
        check("wr_done_pulse", {127'd0, cpu_done}, 128'd0);
    endtask

    // Full read, one-cycle rvalid after each accept; bad_k selects a beat with wrong parity.
    task automatic do_read(input logic [15:0] a, input logic [127:0] d, input int bad_k);
        logic [15:0] ea;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a; bus_ready = 1'b1;
        tick();
        cpu_req = 1'b0;
        check("rd_busy", {127'd0, busy}, 128'd1);
`ifdef BRIDGE_PARITY_EN
        check("rd_par_clr", {127'd0, par_err}, 128'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            ea = a + 16'(i);
            check("rd_valid", {127'd0, bus_valid}, 128'd1);
            check("rd_we", {127'd0, bus_we}, 128'd0);
            check("rd_addr", {112'd0, bus_addr}, {112'd0, ea});
            tick();
            check("rd_wait", {127'd0, bus_valid}, 128'd0);
            bus_rvalid = 1'b1;
            bus_rdata = d[32*i +: 32];
`ifdef BRIDGE_PARITY_EN
            bus_rpar = (^d[32*i +: 32]) ^ (i == bad_k);
`endif
            tick();
            bus_rvalid = 1'b0;
            bus_rdata = 32'hDEAD_BEEF;
`ifdef BRIDGE_PARITY_EN
            check("rd_par_err", {127'd0, par_err}, {127'd0, (bad_k >= 0 && i >= bad_k)});
`endif
            if (i < 3) check("rd_nodone", {127'd0, cpu_done}, 128'd0);
        end
        check("rd_done", {127'd0, cpu_done}, 128'd1);
        check("rd_data", cpu_rdata, d);
        check("rd_busy_off", {127'd0, busy}, 128'd0);
        tick();
        check("rd_done_pulse", {127'd0, cpu_done}, 128'd0);
        check("rd_data_hold", cpu_rdata, d);
`ifdef BRIDGE_PARITY_EN
        check("rd_par_hold", {127'd0, par_err}, {127'd0, bad_k >= 0});
`endif
    endtask

    localparam logic [127:0] WR1 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    localparam logic [127:0] RD2 = {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};
    localparam logic [127:0] WR3 = {32'h0BAD_F00D, 32'h1234_5678, 32'h9ABC_DEF0, 32'hCAFE_BABE};
    localparam logic [127:0] RD4 = {32'h0000_0004, 32'h0000_0003, 32'h8000_0002, 32'hFFFF_FFFF};
    localparam logic [127:0] RD5 = {32'h5555_AAAA, 32'h0F0F_F0F0, 32'h0123_4567, 32'h89AB_CDEF};
    localparam logic [127:0] RD6 = {32'h0000_0007, 32'h1000_0001, 32'h0000_0003, 32'h7777_0000};

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = '0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
`ifdef BRIDGE_PARITY_EN
        bus_rpar = 1'b0;
`endif
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        check("rst_rdata", cpu_rdata, 128'd0);
        check("rst_done", {127'd0, cpu_done}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_valid", {127'd0, bus_valid}, 128'd0);
        check("rst_we", {127'd0, bus_we}, 128'd0);
        check("rst_addr", {112'd0, bus_addr}, 128'd0);
        check("rst_wdata", {96'd0, bus_wdata}, 128'd0);
        tick();

        // 1: plain write, done five edges after the request edge.
        do_write(16'h0010, WR1, -1, 0, 128'd0);
        // 2: plain read, done nine edges after the request edge.
        do_read(16'h0020, RD2, -1);
        // 3: write stalled three cycles on beat 1; read data must survive.
        do_write(16'h0100, WR3, 1, 3, RD2);
        // 4: read with beat addresses wrapping past 0xFFFF.
        do_read(16'hFFFE, RD4, -1);

        // 5: reset while beat 2 of a read is being requested.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040; bus_ready = 1'b1;
        tick();
        cpu_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            bus_rvalid = 1'b1; bus_rdata = 32'h5A5A_0000 + 32'(i);
`ifdef BRIDGE_PARITY_EN
            bus_rpar = ^bus_rdata;
`endif
            tick();
            bus_rvalid = 1'b0;
        end
        check("mid_addr", {112'd0, bus_addr}, 128'h42);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_rdata", cpu_rdata, 128'd0);
        check("mrst_valid", {127'd0, bus_valid}, 128'd0);
        check("mrst_busy", {127'd0, busy}, 128'd0);
        check("mrst_addr", {112'd0, bus_addr}, 128'd0);
        for (int i = 0; i < 3; i++) begin
            bus_rvalid = 1'b1;
            tick();
            check("mrst_nodone", {127'd0, cpu_done}, 128'd0);
            check("mrst_idle", {127'd0, bus_valid}, 128'd0);
        end
        bus_rvalid = 1'b0;
        do_read(16'h0050, RD5, -1);

`ifdef BRIDGE_PARITY_EN
        // 6: wrong parity on beat 1 sets a sticky error that the next request clears.
        do_read(16'h0060, RD6, 1);
        do_write(16'h0070, WR1, -1, 0, RD6);
`else
        do_read(16'h0060, RD6, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
